lru_multiset: RTL



---
 rtl/lru_multiset.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/lru_multiset.sv
// lru_multiset: per-set way-valid bits plus a pairwise age matrix for
// NUM_SETS independent sets. Chooses the replacement way on STORE and
// returns it one cycle later as a registered one-hot and binary index.
// Optional way locking is compiled in with `define LRU_WAY_LOCK_EN.
module lru_multiset #(
    parameter int NUM_WAYS = 4,
    parameter int NUM_SETS = 8,
    localparam int WAY_W = $clog2(NUM_WAYS),
    localparam int SET_W = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                ls_valid_i,
    input  logic [1:0]          ls_op_i,
    input  logic [SET_W-1:0]    ls_set_i,
    input  logic [WAY_W-1:0]    ls_way_i,
    output logic                lru_valid_o,
    output logic [NUM_WAYS-1:0] lru_way_o,
    output logic [WAY_W-1:0]    lru_way_idx_o,
    output logic                lru_evict_o
);

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;
    localparam logic [1:0] OP_INV   = 2'b11;

    // Only entries [i][j] with i > j are meaningful; 1 = way i more recent than way j.
    typedef logic [NUM_WAYS-1:0][NUM_WAYS-1:0] age_t;

    logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
    age_t                age_q   [NUM_SETS];

    logic [SET_W-1:0]    set_idx;
    logic [NUM_WAYS-1:0] cur_valid, cur_lock, cand, oldest, pick;
    age_t                cur_age;
    logic                have_inv, sel_found;
    logic [WAY_W-1:0]    sel_idx;

    logic                wr_en;
    logic [NUM_WAYS-1:0] valid_row_d;
    age_t                age_row_d;
    logic                touch_en;
    logic [WAY_W-1:0]    touch_way;

    logic                lru_valid_q, lru_valid_d;
    logic [NUM_WAYS-1:0] lru_way_q, lru_way_d;
    logic [WAY_W-1:0]    lru_idx_q, lru_idx_d;
    logic                lru_evict_q, lru_evict_d;

    // Out-of-range set indices simply wrap onto the implemented sets.
    assign set_idx = ls_set_i & SET_W'(NUM_SETS - 1);

`ifdef LRU_WAY_LOCK_EN
    logic [NUM_WAYS-1:0] lock_q [NUM_SETS];
    logic [NUM_WAYS-1:0] lock_row_d;
    assign cur_lock = lock_q[set_idx];
`else
    assign cur_lock = '0;
`endif

    // Victim choice: lowest invalid unlocked way, else the oldest unlocked way.
    always_comb begin
        cur_valid = valid_q[set_idx];
        cur_age   = age_q[set_idx];
        cand      = ~cur_valid & ~cur_lock;
        have_inv  = |cand;
        oldest    = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            oldest[w] = ~cur_lock[w];
            for (int j = 0; j < NUM_WAYS; j++) begin
                if (j != w && !cur_lock[j]) begin
                    if (w > j) begin
                        if (cur_age[w][j]) oldest[w] = 1'b0;
                    end else if (!cur_age[j][w]) begin
                        oldest[w] = 1'b0;
                    end
                end
            end
        end
        pick      = have_inv ? cand : oldest;
        sel_found = |pick;
        sel_idx   = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (pick[w]) sel_idx = WAY_W'(w);
        end
    end

    // Request decode: next row contents for the addressed set and next outputs.
    always_comb begin
        wr_en       = 1'b0;
        valid_row_d = cur_valid;
        age_row_d   = cur_age;
        touch_en    = 1'b0;
        touch_way   = ls_way_i;
        lru_valid_d = 1'b0;
        lru_way_d   = lru_way_q;
        lru_idx_d   = lru_idx_q;
        lru_evict_d = lru_evict_q;
`ifdef LRU_WAY_LOCK_EN
        lock_row_d  = cur_lock;
`endif
        if (ls_valid_i) begin
            case (ls_op_i)
                OP_LOAD: begin
                    wr_en    = 1'b1;
                    touch_en = 1'b1;
                end
                OP_STORE: begin
                    lru_valid_d = 1'b1;
                    if (sel_found) begin
                        wr_en                = 1'b1;
                        touch_en             = 1'b1;
                        touch_way            = sel_idx;
                        valid_row_d[sel_idx] = 1'b1;
                        lru_way_d            = NUM_WAYS'(1) << sel_idx;
                        lru_idx_d            = sel_idx;
                        lru_evict_d          = ~have_inv;
                    end else begin
                        lru_way_d   = '0;
                        lru_idx_d   = '0;
                        lru_evict_d = 1'b0;
                    end
                end
                OP_INV: begin
                    wr_en                 = 1'b1;
                    valid_row_d[ls_way_i] = 1'b0;
`ifdef LRU_WAY_LOCK_EN
                    lock_row_d[ls_way_i]  = 1'b0;
`endif
                end
                default: begin
`ifdef LRU_WAY_LOCK_EN
                    wr_en                = 1'b1;
                    lock_row_d[ls_way_i] = 1'b1;
`endif
                end
            endcase
        end
        // Touch as MRU: row of the way set, its column cleared.
        if (touch_en) begin
            for (int i = 1; i < NUM_WAYS; i++) begin
                for (int j = 0; j < i; j++) begin
                    if (WAY_W'(i) == touch_way)      age_row_d[i][j] = 1'b1;
                    else if (WAY_W'(j) == touch_way) age_row_d[i][j] = 1'b0;
                end
            end
        end
    end

    for (genvar gi = 0; gi < NUM_SETS; gi++) begin : g_set
        // Per-set state register, written only when its set is addressed.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                valid_q[gi] <= '0;
                age_q[gi]   <= '0;
`ifdef LRU_WAY_LOCK_EN
                lock_q[gi]  <= '0;
`endif
            end else if (wr_en && (set_idx == SET_W'(gi))) begin
                valid_q[gi] <= valid_row_d;
                age_q[gi]   <= age_row_d;
`ifdef LRU_WAY_LOCK_EN
                lock_q[gi]  <= lock_row_d;
`endif
            end
        end
    end

    // Registered STORE response.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lru_valid_q <= 1'b0;
            lru_way_q   <= '0;
            lru_idx_q   <= '0;
            lru_evict_q <= 1'b0;
        end else begin
            lru_valid_q <= lru_valid_d;
            lru_way_q   <= lru_way_d;
            lru_idx_q   <= lru_idx_d;
            lru_evict_q <= lru_evict_d;
        end
    end

    assign lru_valid_o   = lru_valid_q;
    assign lru_way_o     = lru_way_q;
    assign lru_way_idx_o = lru_idx_q;
    assign lru_evict_o   = lru_evict_q;

endmodule
